// File: rtl/switch_debounce_sync_if.sv
// Switch-conditioning bundle: raw switch levels in, debounced vector plus
// change strobe, busy flag and wrapping change count out.
interface switch_debounce_sync_if #(
    parameter int WIDTH = 18
);
    logic [WIDTH-1:0] SWITCH_I;
    logic [WIDTH-1:0] SWITCH_DEBOUNCED_O;
    logic             SWITCH_CHANGE_O;
    logic             SWITCH_BUSY_O;
    logic [7:0]       CHANGE_COUNT_O;

    modport master (
        output SWITCH_I,
        input  SWITCH_DEBOUNCED_O,
        input  SWITCH_CHANGE_O,
        input  SWITCH_BUSY_O,
        input  CHANGE_COUNT_O
    );

    modport slave (
        input  SWITCH_I,
        output SWITCH_DEBOUNCED_O,
        output SWITCH_CHANGE_O,
        output SWITCH_BUSY_O,
        output CHANGE_COUNT_O
    );
endinterface

// File: rtl/switch_debounce_sync.sv
// Synchronises the raw switch vector and debounces it as one vector with a
// shared stability counter; emits a change strobe and a wrapping change count.
module switch_debounce_sync #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 24
) (
    input  logic                   CLOCK_50_I,
    input  logic                   RESET_I,
    switch_debounce_sync_if.slave  sw
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] sync3_q, sync3_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_q, chg_d;
    logic [7:0]       ccount_q, ccount_d;
    state_t           state_q, state_d;

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
            deb_q    <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
            ccount_q <= '0;
            state_q  <= IDLE;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sync3_q  <= sync3_d;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
            ccount_q <= ccount_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        sync1_d  = sw.SWITCH_I;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        deb_d    = deb_q;
        cnt_d    = cnt_q;
        chg_d    = 1'b0;
        ccount_d = ccount_q;
        state_d  = state_q;

        case (state_q)
            IDLE: begin
                if (sync2_q != deb_q) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                // A return to the accepted vector abandons the candidate silently.
                if (sync2_q == deb_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sync2_q != sync3_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    deb_d    = sync2_q;
                    chg_d    = 1'b1;
                    ccount_d = ccount_q + 8'd1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sw.SWITCH_DEBOUNCED_O = deb_q;
        sw.SWITCH_CHANGE_O    = chg_q;
        sw.SWITCH_BUSY_O      = (state_q == COUNT);
        sw.CHANGE_COUNT_O     = ccount_q;
    end

endmodule
